// File: rtl/usb_phy_apb_seq.sv
// USB PHY bring-up sequencer: replays a register-write table over APB, polls the
//   PHY lock status until match or timeout, then lends the APB port to the CPU.
// Latency: one SETUP + at least one ACCESS cycle per transfer; table writes run back-to-back.
// Backpressure: ACCESS holds until pready; CPU requests wait (no ack) until DONE/ERR.
// Ports: pclk/presetn clock and async active-low reset; start begins bring-up;
//   tbl_addr/tbl_data/tbl_count form the write table; cpu_* is the CPU requester;
//   psel/penable/pwrite/paddr/pwdata/prdata/pready form the APB master port;
//   phy_utmi_reset holds the PHY UTMI side in reset; seq_busy/seq_done/seq_err report status.
module usb_phy_apb_seq #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter logic [31:0] POLL_ADDR   = 32'h0000_0040,
  parameter logic [31:0] POLL_MASK   = 32'h0000_0001,
  parameter int unsigned POLL_GAP    = 16,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic                               pclk,
  input  logic                               presetn,
  input  logic                               start,
  input  logic [NUM_ENTRIES*32-1:0]          tbl_addr,
  input  logic [NUM_ENTRIES*32-1:0]          tbl_data,
  input  logic [$clog2(NUM_ENTRIES+1)-1:0]   tbl_count,
  input  logic                               cpu_req,
  input  logic                               cpu_write,
  input  logic [31:0]                        cpu_addr,
  input  logic [31:0]                        cpu_wdata,
  output logic                               cpu_ack,
  output logic [31:0]                        cpu_rdata,
  output logic                               psel,
  output logic                               penable,
  output logic                               pwrite,
  output logic [31:0]                        paddr,
  output logic [31:0]                        pwdata,
  input  logic [31:0]                        prdata,
  input  logic                               pready,
  output logic                               phy_utmi_reset,
  output logic                               seq_busy,
  output logic                               seq_done,
  output logic                               seq_err
);

  localparam int CW = $clog2(NUM_ENTRIES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [CW-1:0] NUM_MAX  = CW'(NUM_ENTRIES);
  localparam logic [TW-1:0] TMO_LIM  = TW'(TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    IDLE, WR_SETUP, WR_ACCESS, POLL_SETUP, POLL_ACCESS, POLL_WAIT,
    DONE, ERR, CPU_SETUP, CPU_ACCESS
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] n_q, n_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic          pwrite_q, pwrite_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          utmi_rst_q, utmi_rst_d;
  logic          start_pend_q, start_pend_d;
  logic          ret_err_q, ret_err_d;

  logic [CW-1:0] idx_inc;
  logic [CW-1:0] n_eff;
  logic [31:0]   nxt_addr;
  logic [31:0]   nxt_data;
  logic          poll_match;
  logic          tmo_hit;
  logic          accept_start;
  logic          go_poll;
  logic          in_poll;

  assign idx_inc    = idx_q + CW'(1);
  assign n_eff      = (tbl_count > NUM_MAX) ? NUM_MAX : tbl_count;
  assign poll_match = ((prdata & POLL_MASK) == POLL_MASK);
  assign tmo_hit    = (tmo_q >= TMO_LIM);
  assign in_poll    = (state_q == POLL_SETUP) || (state_q == POLL_ACCESS) ||
                      (state_q == POLL_WAIT);

  // Table entry for the next back-to-back write (entry 0 is taken directly on start).
  always_comb begin
    nxt_addr = '0;
    nxt_data = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (idx_inc == CW'(i)) begin
        nxt_addr = tbl_addr[32*i +: 32];
        nxt_data = tbl_data[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    n_d          = n_q;
    gap_d        = gap_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pwrite_d     = pwrite_q;
    cpu_ack_d    = 1'b0;
    cpu_rdata_d  = '0;
    done_d       = done_q;
    err_d        = err_q;
    utmi_rst_d   = utmi_rst_q;
    start_pend_d = start_pend_q;
    ret_err_d    = ret_err_q;
    accept_start = 1'b0;
    go_poll      = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        // UTMI reset releases one cycle after DONE is entered.
        if (state_q == DONE) utmi_rst_d = 1'b0;
        if (start || start_pend_q) begin
          accept_start = 1'b1;
        end else if ((state_q != IDLE) && cpu_req && !cpu_ack_q) begin
          // cpu_ack_q blocks re-sampling the request that was just acked.
          state_d   = CPU_SETUP;
          ret_err_d = (state_q == ERR);
          paddr_d   = cpu_addr;
          pwdata_d  = cpu_wdata;
          pwrite_d  = cpu_write;
        end
      end
      WR_SETUP: state_d = WR_ACCESS;
      WR_ACCESS: begin
        if (pready) begin
          idx_d = idx_inc;
          if (idx_inc == n_q) begin
            go_poll = 1'b1;
          end else begin
            state_d  = WR_SETUP;
            paddr_d  = nxt_addr;
            pwdata_d = nxt_data;
          end
        end
      end
      POLL_SETUP: state_d = POLL_ACCESS;
      POLL_ACCESS: begin
        if (pready) begin
          // A match wins over a simultaneous timeout.
          if (poll_match) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (tmo_hit) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = POLL_WAIT;
            gap_d   = '0;
          end
        end
      end
      POLL_WAIT: begin
        if (gap_q == GAP_LAST) begin
          if (tmo_hit) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = POLL_SETUP;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      CPU_SETUP: begin
        state_d = CPU_ACCESS;
        if (start) start_pend_d = 1'b1;
      end
      CPU_ACCESS: begin
        if (start) start_pend_d = 1'b1;
        if (pready) begin
          cpu_ack_d   = 1'b1;
          cpu_rdata_d = pwrite_q ? 32'h0 : prdata;
          state_d     = ret_err_q ? ERR : DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_start) begin
      start_pend_d = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      utmi_rst_d   = 1'b1;
      idx_d        = '0;
      n_d          = n_eff;
      if (n_eff == '0) begin
        go_poll = 1'b1;
      end else begin
        state_d  = WR_SETUP;
        paddr_d  = tbl_addr[31:0];
        pwdata_d = tbl_data[31:0];
        pwrite_d = 1'b1;
      end
    end

    if (go_poll) begin
      state_d  = POLL_SETUP;
      paddr_d  = POLL_ADDR;
      pwdata_d = '0;
      pwrite_d = 1'b0;
    end
  end

  // Poll-phase timer: zeroed on entry to the poll phase, then saturating.
  always_comb begin
    tmo_d = tmo_q;
    if (go_poll) begin
      tmo_d = '0;
    end else if (in_poll && (tmo_q != TMO_LIM)) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      n_q          <= '0;
      tmo_q        <= '0;
      gap_q        <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      utmi_rst_q   <= 1'b1;
      start_pend_q <= 1'b0;
      ret_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      n_q          <= n_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pwrite_q     <= pwrite_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      utmi_rst_q   <= utmi_rst_d;
      start_pend_q <= start_pend_d;
      ret_err_q    <= ret_err_d;
    end
  end

  // psel/penable decode straight from state so an async reset drops them at once.
  assign psel    = (state_q == WR_SETUP)  || (state_q == WR_ACCESS)   ||
                   (state_q == POLL_SETUP) || (state_q == POLL_ACCESS) ||
                   (state_q == CPU_SETUP) || (state_q == CPU_ACCESS);
  assign penable = (state_q == WR_ACCESS) || (state_q == POLL_ACCESS) ||
                   (state_q == CPU_ACCESS);
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

  assign seq_busy       = (state_q == WR_SETUP) || (state_q == WR_ACCESS) || in_poll;
  assign seq_done       = done_q;
  assign seq_err        = err_q;
  assign phy_utmi_reset = utmi_rst_q;
  assign cpu_ack        = cpu_ack_q;
  assign cpu_rdata      = cpu_rdata_q;

endmodule
